half_argmax: RTL
================

Name: half_argmax

Overview:
- Back-end reader for half_predict.
- Detects the predictor's done, snapshots the OUTPUT_NODES binary16 scores y[], and scans them sequentially, one per cycle.
- Presents the winning class index and its score on a valid/ready output handshake.
- Sits between half_predict and the result/score logic (bench scoreboard or downstream accuracy counter).

Parameters:
- OUTPUT_NODES, 10, number of half-precision scores to scan (>=1).
- IDX_W, $clog2(OUTPUT_NODES) (min 1), width of class_idx.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- done  input  1  completion level/pulse from half_predict.
- y  input  16 x OUTPUT_NODES  unpacked array of binary16 scores, valid while done is high.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- class_idx  output  IDX_W  index of maximum score.
- max_value  output  16  binary16 maximum score.
- all_nan  output  1  every score was NaN.
- busy  output  1  state != IDLE.
- dropped  output  1  sticky: a done rising edge was ignored while busy.

Behaviour:
- Reset (async, rstn=0): state=IDLE. out_valid=0, class_idx=0, max_value=16'h0000, all_nan=0, busy=0, dropped=0, done_q=0. A reset mid-scan or mid-handshake aborts immediately with no output.
- Start: done_q registers done every cycle; start = done & ~done_q. A level-held done therefore triggers exactly once.
- IDLE, start sampled at edge E0:
  - snap[] <= y[].
  - best <= y[0]; best_idx <= 0; best_ok <= !isnan(y[0]); ptr <= 1.
  - state <= SCAN, or RESULT if OUTPUT_NODES==1.
- SCAN, one compare per edge on snap[ptr]:
  - If !isnan(snap[ptr]) && (!best_ok || gt(snap[ptr], best)): best, best_idx <= snap[ptr], ptr; best_ok <= 1.
  - If ptr == OUTPUT_NODES-1: state <= RESULT. Otherwise ptr <= ptr+1.
- Latency: out_valid rises after edge E(OUTPUT_NODES-1), i.e. 9 cycles after the capture edge for the default.
- RESULT:
  - out_valid=1. class_idx/max_value/all_nan are held stable until the handshake completes.
  - all_nan = !best_ok. When all_nan=1: class_idx=0, max_value=16'h7E00.
  - Transfer when out_valid & out_ready at an edge: state <= IDLE, out_valid <= 0 the same edge. Outputs keep their last value afterwards.
- out_ready already high on entry to RESULT: out_valid is high for exactly one cycle.
- start while state != IDLE (SCAN or RESULT): ignored, no re-snapshot, dropped <= 1 (sticky until reset).
- start in the same cycle the RESULT transfer completes: also ignored and counted as dropped. A new capture requires state==IDLE at the sampled edge.
- Comparison gt(a,b), binary16:
  - NaN: exponent 5'h1F and mantissa != 0.
  - Normalise -0 (16'h8000) to +0.
  - Order key: sign 0 -> {1'b1, h[14:0]}; sign 1 -> {1'b0, ~h[14:0]}.
  - gt = key(a) > key(b), strict, so ties keep the lowest index.
  - Infinities order naturally: +inf is max, -inf is min.

Decomposition:
- conversions_pkg gains:
  - typedef logic [15:0] half_t;
  - localparam HALF_QNAN = 16'h7E00;
  - functions half_is_nan(half_t) and half_order_key(half_t) returning 16-bit unsigned. half_order_key handles the -0 normalisation.
- FSM state enum (IDLE, SCAN, RESULT) stays local to the module.
- One combinational sub-module, half_gt (a, b -> gt), built on the package functions; reusable by other scoring blocks.

Test Plan:
- y={3C00,4000,BC00,3800,0,0,0,0,0,0}, done held high 50 cycles -> single result: class_idx=1, max_value=4000, all_nan=0. out_valid 9 cycles after capture edge. dropped=0.
- Tie: y[3]=y[7]=4400, rest 3C00 -> class_idx=3, max_value=4400.
- NaN and signs: y[0]=7E00, y[1]=8000, y[2]=0000, rest BC00 -> class_idx=1 (first of the +0/-0 tie), max_value=8000. Separately all y=7E01 -> all_nan=1, class_idx=0, max_value=7E00.
- Infinities: y[5]=7C00, y[9]=FC00, rest 7BFF -> class_idx=5, max_value=7C00.
- Backpressure: out_ready=0 for 20 cycles -> outputs stable, out_valid high throughout. Second done edge during the wait -> dropped=1 and the result is unchanged. Raising out_ready -> one transfer, then IDLE.
- Reset mid-SCAN at cycle 4 after capture -> out_valid never asserts, all outputs at reset values. Next done edge gives a correct fresh result.

Source files
------------

// File: rtl/conversions_pkg.sv
// Shared binary16 helpers: NaN detection and a total-order key for compares.
package conversions_pkg;

    typedef logic [15:0] half_t;

    localparam half_t HALF_QNAN = 16'h7E00;

    // NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic half_is_nan(input half_t h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
    endfunction

    // Unsigned key whose integer order matches the numeric order of non-NaN
    // halves. -0 is folded onto +0 so the two compare equal.
    function automatic logic [15:0] half_order_key(input half_t h);
        half_t n;
        n = (h == 16'h8000) ? 16'h0000 : h;
        return n[15] ? {1'b0, ~n[14:0]} : {1'b1, n[14:0]};
    endfunction

endpackage

// File: rtl/half_gt.sv
// Strict a > b on binary16 values; NaN filtering is left to the caller.
module half_gt
    import conversions_pkg::*;
(
    input  half_t a,
    input  half_t b,
    output logic  gt
);

    assign gt = half_order_key(a) > half_order_key(b);

endmodule

// File: rtl/half_argmax.sv
// Snapshots half_predict scores on done's rising edge and scans them one per
// cycle, presenting the argmax on a valid/ready handshake.
module half_argmax
    import conversions_pkg::*;
#(
    parameter int OUTPUT_NODES = 10,
    parameter int IDX_W        = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             done,
    input  logic [15:0]      y [OUTPUT_NODES],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] class_idx,
    output logic [15:0]      max_value,
    output logic             all_nan,
    output logic             busy,
    output logic             dropped
);

    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUTPUT_NODES - 1);

    state_t           state, state_nxt;
    logic             done_q, start;
    half_t            snap [OUTPUT_NODES];
    half_t            best, cand, fin_best;
    logic [IDX_W-1:0] best_idx, ptr, fin_idx;
    logic             best_ok, cand_gt, take, fin_ok, enter_result;

    assign start     = done & ~done_q;
    assign out_valid = (state == RESULT);
    assign busy      = (state != IDLE);

    assign cand = snap[ptr];

    half_gt u_gt (
        .a  (cand),
        .b  (best),
        .gt (cand_gt)
    );

    // Next state plus the final best value that gets latched into the outputs
    // on entry to RESULT (from y[0] directly when there is only one score).
    always_comb begin
        state_nxt = state;
        take      = !half_is_nan(cand) && (!best_ok || cand_gt);
        fin_best  = take ? cand : best;
        fin_idx   = take ? ptr  : best_idx;
        fin_ok    = best_ok | take;
        case (state)
            IDLE: begin
                if (start) state_nxt = (OUTPUT_NODES == 1) ? RESULT : SCAN;
                fin_best = y[0];
                fin_idx  = '0;
                fin_ok   = !half_is_nan(y[0]);
            end
            SCAN:    if (ptr == LAST) state_nxt = RESULT;
            RESULT:  if (out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        enter_result = (state_nxt == RESULT) && (state != RESULT);
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Snapshot, running best, output holding registers and drop flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q    <= 1'b0;
            for (int i = 0; i < OUTPUT_NODES; i++) snap[i] <= '0;
            best      <= '0;
            best_idx  <= '0;
            best_ok   <= 1'b0;
            ptr       <= '0;
            class_idx <= '0;
            max_value <= '0;
            all_nan   <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            done_q <= done;
            if (start && state != IDLE) dropped <= 1'b1;
            if (state == IDLE && start) begin
                snap     <= y;
                best     <= y[0];
                best_idx <= '0;
                best_ok  <= !half_is_nan(y[0]);
                ptr      <= IDX_W'(1);
            end else if (state == SCAN) begin
                best     <= fin_best;
                best_idx <= fin_idx;
                best_ok  <= fin_ok;
                if (ptr != LAST) ptr <= ptr + IDX_W'(1);
            end
            if (enter_result) begin
                class_idx <= fin_ok ? fin_idx : '0;
                max_value <= fin_ok ? fin_best : HALF_QNAN;
                all_nan   <= !fin_ok;
            end
        end
    end

endmodule
